// File: rtl/load_store_unit.sv
// Single-port load/store unit between the core execute stage and memory.
// Builds store masks/lane data, extends load lanes, flags misalignment and read timeouts.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_misaligned,
    output logic        resp_bus_error,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic        mem_enable,
    output logic        mem_cmd,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_load_data,
    input  logic        mem_valid
);

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic        lat_store;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [CW-1:0] tmo_cnt;

    logic        req_misaligned;
    logic        tmo_done;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] load_ext;

    assign req_misaligned = (req_size == 2'd3) ||
                            (req_size == 2'd1 && req_addr[0]) ||
                            (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    assign tmo_done  = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid) state_next = req_misaligned ? RESP : ACCESS;
            ACCESS:  if (lat_store || mem_valid || tmo_done) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane mask and replicated store data come only from latched fields so they
    // stay stable across the whole enable window.
    always_comb begin
        lane_mask  = 4'b1111;
        lane_wdata = lat_wdata;
        case (lat_size)
            2'd0: begin
                lane_mask  = 4'b0001 << lat_addr[1:0];
                lane_wdata = {4{lat_wdata[7:0]}};
            end
            2'd1: begin
                lane_mask  = 4'b0011 << {lat_addr[1], 1'b0};
                lane_wdata = {2{lat_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = mem_load_data[8*lat_addr[1:0] +: 8];
        h = mem_load_data[16*lat_addr[1] +: 16];
        case (lat_size)
            2'd0:    load_ext = lat_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    load_ext = lat_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_ext = mem_load_data;
        endcase
    end

    always_comb begin
        mem_enable     = 1'b0;
        mem_addr       = '0;
        mem_mask       = '0;
        mem_cmd        = MEM_CMD_READ;
        mem_write_data = '0;
        if (state == ACCESS) begin
            mem_enable     = 1'b1;
            mem_addr       = {lat_addr[31:2], 2'b00};
            mem_mask       = lane_mask;
            mem_cmd        = lat_store ? MEM_CMD_WRITE : MEM_CMD_READ;
            mem_write_data = lane_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_store       <= 1'b0;
            lat_size        <= '0;
            lat_unsigned    <= 1'b0;
            lat_addr        <= '0;
            lat_wdata       <= '0;
            tmo_cnt         <= '0;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_misaligned <= 1'b0;
            resp_bus_error  <= 1'b0;
        end else begin
            resp_valid <= (state_next == RESP);
            case (state)
                IDLE: if (req_valid) begin
                    lat_store       <= req_store;
                    lat_size        <= req_size;
                    lat_unsigned    <= req_unsigned;
                    lat_addr        <= req_addr;
                    lat_wdata       <= req_wdata;
                    tmo_cnt         <= '0;
                    resp_data       <= '0;
                    resp_bus_error  <= 1'b0;
                    resp_misaligned <= req_misaligned;
                end
                ACCESS: begin
                    if (lat_store)      resp_data <= '0;
                    else if (mem_valid) resp_data <= load_ext;
                    else if (tmo_done) begin
                        resp_data      <= '0;
                        resp_bus_error <= 1'b1;
                    end else tmo_cnt <= tmo_cnt + 1'b1;
                end
                RESP: if (resp_ready) begin
                    resp_data       <= '0;
                    resp_misaligned <= 1'b0;
                    resp_bus_error  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a small level-sensitive memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_misaligned, resp_bus_error;
    logic [31:0] resp_data;
    logic [31:0] mem_addr, mem_write_data, mem_load_data;
    logic [3:0]  mem_mask;
    logic        mem_enable, mem_cmd, mem_valid;
    logic        stall;

    logic [31:0] mem [0:63];

    typedef struct {
        logic        store;
        logic [31:0] data;
        logic        mis;
        logic        berr;
        logic [3:0]  mask;
        logic [31:0] wd;
        logic [31:0] addr;
        int          en;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   en_cnt  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_misaligned(resp_misaligned), .resp_bus_error(resp_bus_error),
        .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_enable(mem_enable),
        .mem_cmd(mem_cmd), .mem_write_data(mem_write_data),
        .mem_load_data(mem_load_data), .mem_valid(mem_valid)
    );

    assign mem_load_data = mem[mem_addr[7:2]];
    assign mem_valid     = mem_enable && (mem_cmd == 1'b0) && !stall;

    always @(posedge clk) begin
        if (mem_enable && mem_cmd) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory-port monitor: every enable cycle is counted and checked against the pending request.
    always @(negedge clk) begin
        if (mem_enable) begin
            en_cnt++;
            if (sb.size() != 0) begin
                check("mem_addr", mem_addr, sb[0].addr);
                check("mem_mask", {28'h0, mem_mask}, {28'h0, sb[0].mask});
                check("mem_cmd", {31'h0, mem_cmd}, {31'h0, sb[0].store});
                if (sb[0].store) check("mem_wdata", mem_write_data, sb[0].wd);
            end
        end
    end

    task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] e_data, input logic e_mis, input logic e_berr,
                          input logic [3:0] e_mask, input logic [31:0] e_wd,
                          input int e_en, input int e_lat, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'd1);
        e.store = st; e.data = e_data; e.mis = e_mis; e.berr = e_berr;
        e.mask = e_mask; e.wd = e_wd; e.addr = {addr[31:2], 2'b00}; e.en = e_en;
        sb.push_back(e);
        en_cnt       = 0;
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        resp_ready   = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, e_lat);
        if (!resp_valid) begin
            resp_ready = 1'b1;
            void'(sb.pop_front());
            return;
        end
        got = sb.pop_front();
        check("resp_data", resp_data, got.data);
        check("resp_mis", {31'h0, resp_misaligned}, {31'h0, got.mis});
        check("resp_berr", {31'h0, resp_bus_error}, {31'h0, got.berr});
        check("enable_cycles", en_cnt, got.en);
        for (int i = 0; i < hold; i++) begin
            // Request inputs waved while stalled must be ignored.
            req_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", {31'h0, resp_valid}, 32'd1);
            check("hold_data", resp_data, got.data);
            check("hold_req_ready", {31'h0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("resp_cleared", {31'h0, resp_valid}, 32'd0);
        check("enable_after", en_cnt, got.en);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
        check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
        check({tag, "_resp_flags"}, {30'h0, resp_misaligned, resp_bus_error}, 32'd0);
        check({tag, "_resp_data"}, resp_data, 32'd0);
        check({tag, "_mem_enable"}, {31'h0, mem_enable}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_mask"}, {28'h0, mem_mask}, 32'd0);
        check({tag, "_mem_wdata"}, mem_write_data, 32'd0);
        check({tag, "_mem_cmd"}, {31'h0, mem_cmd}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("post_rst");

        //      st  sz   uns  addr   wdata          data          mis  berr mask     wd            en lat hold
        do_req(0, 2'd0, 0, 32'h11, 32'h0,        32'hFFFFFFAA, 0, 0, 4'b0010, 32'h0,        1, 2, 0);
        do_req(0, 2'd1, 1, 32'h12, 32'h0,        32'h00008899, 0, 0, 4'b1100, 32'h0,        1, 2, 0);
        do_req(0, 2'd1, 0, 32'h12, 32'h0,        32'hFFFF8899, 0, 0, 4'b1100, 32'h0,        1, 2, 0);
        do_req(1, 2'd0, 0, 32'h13, 32'h1234565C, 32'h0,        0, 0, 4'b1000, 32'h5C5C5C5C, 1, 2, 0);
        check("mem_word_0x10", mem[4], 32'h5C99AABB);
        do_req(0, 2'd2, 0, 32'h10, 32'h0,        32'h5C99AABB, 0, 0, 4'b1111, 32'h0,        1, 2, 0);
        do_req(0, 2'd0, 1, 32'h10, 32'h0,        32'h000000BB, 0, 0, 4'b0001, 32'h0,        1, 2, 0);
        do_req(0, 2'd2, 0, 32'h22, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        0, 1, 0);
        do_req(0, 2'd3, 0, 32'h10, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        0, 1, 0);
        do_req(1, 2'd1, 0, 32'h11, 32'hFFFF,     32'h0,        1, 0, 4'b0000, 32'h0,        0, 1, 0);
        do_req(1, 2'd1, 0, 32'h16, 32'hABCD1234, 32'h0,        0, 0, 4'b1100, 32'h12341234, 1, 2, 0);
        do_req(0, 2'd2, 0, 32'h14, 32'h0,        32'h12340000, 0, 0, 4'b1111, 32'h0,        1, 2, 0);
        do_req(1, 2'd2, 0, 32'h18, 32'hCAFEF00D, 32'h0,        0, 0, 4'b1111, 32'hCAFEF00D, 1, 2, 0);
        do_req(0, 2'd0, 0, 32'h1B, 32'h0,        32'hFFFFFFCA, 0, 0, 4'b1000, 32'h0,        1, 2, 0);
        do_req(0, 2'd1, 1, 32'h18, 32'h0,        32'h0000F00D, 0, 0, 4'b0011, 32'h0,        1, 2, 0);
        stall = 1'b1;
        do_req(0, 2'd2, 0, 32'h40, 32'h0,        32'h0,        0, 1, 4'b1111, 32'h0,       16, 17, 0);
        stall = 1'b0;
        do_req(0, 2'd2, 0, 32'h10, 32'h0,        32'h5C99AABB, 0, 0, 4'b1111, 32'h0,        1, 2, 5);

        // Reset while a stalled read is in ACCESS.
        stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("access_enable", {31'h0, mem_enable}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst");
        reset = 1'b0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check("no_stale_resp", {31'h0, resp_valid}, 32'd0);
        check("no_stale_enable", {31'h0, mem_enable}, 32'd0);

        do_req(0, 2'd0, 0, 32'h12, 32'h0,        32'hFFFFFF99, 0, 0, 4'b0100, 32'h0,        1, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
